muldiv_unit: RTL and testbench

- Iterative multiply/divide unit that produces the HI/LO pair for MULT, MULTU, DIV and DIVU.
- Sits beside the EX-stage ALU. The pipeline holds IF/ID and bubbles ID/EX while `busy` is high.
- `hi_out`/`lo_out` and `done` feed the HI/LO write-back path.
- Width is parametrised. It replaces single-cycle HI/LO arithmetic with a multi-cycle, abortable engine.

---
 rtl/muldiv_unit.sv | 119 +++++++++++
 tb/tb_muldiv_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide engine producing HI/LO for MULT, MULTU, DIV, DIVU.
// Latency: DATA_WIDTH+2 cycles from start to the done pulse; flush aborts without a result.
// Backpressure: start is ignored while busy; the pipeline stalls on busy, so there is no queueing.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out
);

  localparam int W         = DATA_WIDTH;
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t               state, state_d;
  logic [CNT_WIDTH-1:0] cnt;
  logic [2*W-1:0]       acc;
  logic [W-1:0]         opnd;
  logic                 is_div, neg_res, neg_rem, div_zero;

  logic                 accept, last_step;
  logic                 signed_op, a_neg, b_neg;
  logic [W-1:0]         mag_a, mag_b;
  logic [W:0]           mul_sum, div_shift, div_diff;
  logic [2*W-1:0]       mul_next, div_next, prod;
  logic [W-1:0]         quo, rem;

  assign accept    = start && !flush && (state == IDLE || state == DONE);
  assign last_step = (cnt == CNT_WIDTH'(W - 1));

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & src_a[W-1];
  assign b_neg     = signed_op & src_b[W-1];
  assign mag_a     = a_neg ? -src_a : src_a;
  assign mag_b     = b_neg ? -src_b : src_b;

  // Multiply: acc = {partial product, remaining multiplier bits}, opnd = |multiplicand|.
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
  assign mul_next = acc[0] ? {mul_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting into quotient}, opnd = |divisor|.
  assign div_shift = {acc[2*W-1:W], acc[W-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_next  = div_diff[W] ? {div_shift[W-1:0], acc[W-2:0], 1'b0}
                                 : {div_diff[W-1:0],  acc[W-2:0], 1'b1};

  assign prod = neg_res ? -acc : acc;
  assign quo  = neg_res ? -acc[W-1:0] : acc[W-1:0];
  assign rem  = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (flush) state_d = IDLE;
               else if (last_step) state_d = FIXUP;
      FIXUP:   state_d = flush ? IDLE : DONE;
      DONE:    state_d = accept ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d == CALC) || (state_d == FIXUP);
      done  <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
    end else if (accept) begin
      cnt      <= '0;
      is_div   <= op[1];
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= op[1] && (src_b == '0);
      acc      <= op[1] ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
      opnd     <= op[1] ? mag_b : mag_a;
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      acc <= is_div ? div_next : mul_next;
    end else if (state == FIXUP && !flush) begin
      // A zero divisor leaves |dividend| as remainder, so only the quotient needs overriding.
      if (is_div) begin
        hi_out <= rem;
        lo_out <= div_zero ? {W{1'b1}} : quo;
      end else begin
        hi_out <= prod[2*W-1:W];
        lo_out <= prod[W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at DATA_WIDTH=32: arithmetic, latency, back-to-back, flush and reset.
module tb_muldiv_unit;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi_out, lo_out;

  int tests = 0;
  int fails = 0;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
  endtask

  // Takes the start edge, then waits for done; hold>0 keeps a bogus start asserted while busy.
  task automatic wait_done(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input int hold);
    int  n, bc;
    bit  seen;
    n = 0; bc = 0; seen = 0;
    tick();
    if (busy) bc++;
    if (hold == 0) start = 1'b0;
    else begin
      op = DIVU; src_a = 32'd1; src_b = 32'd1;
    end
    while (!seen && n < 100) begin
      tick();
      n++;
      if (n >= hold) start = 1'b0;
      if (busy) bc++;
      if (done) seen = 1'b1;
    end
    check({tag, " latency"}, n, 32'd33);
    check({tag, " busy_cycles"}, bc, 32'd33);
    check({tag, " hi"}, hi_out, exp_hi);
    check({tag, " lo"}, lo_out, exp_lo);
  endtask

  initial begin
    int dn;
    rst_n = 1'b0; start = 1'b0; op = MULT; src_a = '0; src_b = '0; flush = 1'b0;
    #12;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset hi", hi_out, 32'd0);
    check("reset lo", lo_out, 32'd0);
    rst_n = 1'b1;
    tick();

    // Signed multiply with mixed signs, then single-cycle done width.
    issue(MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_done("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
    tick();
    check("done_pulse_width", {31'd0, done}, 32'd0);
    check("idle_after_done busy", {31'd0, busy}, 32'd0);

    // Unsigned max squared, then DIVU issued during the DONE cycle.
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 0);
    issue(DIVU, 32'd100, 32'd7);
    wait_done("divu_b2b", 32'd2, 32'd14, 0);

    tick();
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    tick();
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 32'd0, 32'h8000_0000, 0);
    tick();
    issue(DIVU, 32'h1234_5678, 32'd0);
    wait_done("divu_zero", 32'h1234_5678, 32'hFFFF_FFFF, 0);
    tick();

    // Flush ten cycles into a multiply: no done, results untouched.
    dn = 0;
    issue(MULT, 32'd5, 32'd6);
    tick();
    start = 1'b0;
    repeat (9) begin
      tick();
      if (done) dn++;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy_low", {31'd0, busy}, 32'd0);
    repeat (40) begin
      tick();
      if (done) dn++;
    end
    check("flush no_done", dn, 32'd0);
    check("flush hi_kept", hi_out, 32'h1234_5678);
    check("flush lo_kept", lo_out, 32'hFFFF_FFFF);

    // start and flush together in IDLE start nothing.
    issue(MULT, 32'd5, 32'd6);
    flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("start_flush busy", {31'd0, busy}, 32'd0);
    dn = 0;
    repeat (40) begin
      tick();
      if (done) dn++;
    end
    check("start_flush no_done", dn, 32'd0);

    // A start held during busy must not disturb the running multiply.
    issue(MULT, 32'd5, 32'd6);
    wait_done("mult_start_busy", 32'd0, 32'd30, 6);
    tick();

    // Asynchronous reset between edges mid-CALC, then a clean operation.
    issue(MULTU, 32'h0000_FFFF, 32'h0000_FFFF);
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst busy", {31'd0, busy}, 32'd0);
    check("arst done", {31'd0, done}, 32'd0);
    check("arst hi", hi_out, 32'd0);
    check("arst lo", lo_out, 32'd0);
    #3 rst_n = 1'b1;
    tick();
    issue(MULTU, 32'd7, 32'd9);
    wait_done("after_reset", 32'd0, 32'd63, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
